// File: rtl/wm_pkg.sv
// Shared constants, FSM states and decode payload for the watermark APB loader.
package wm_pkg;

   localparam int unsigned AMBA_WORD       = 16;
   localparam int unsigned AMBA_ADDR_DEPTH = 20;
   localparam int unsigned PADDR_W         = AMBA_ADDR_DEPTH + 1;
   localparam int unsigned DATA_DEPTH      = 8;
   localparam int unsigned SIDE_W          = 10;
   localparam int unsigned SQ_W            = 20;
   // Wide enough for PADDR and for np_sq + nw_sq without overflow.
   localparam int unsigned SPAN_W          = 22;
   localparam int unsigned CFG_W           = 18;

   localparam int unsigned ADDR_CTRL   = 0;
   localparam int unsigned ADDR_IWHITE = 1;
   localparam int unsigned ADDR_NP     = 2;
   localparam int unsigned ADDR_NW     = 3;
   localparam int unsigned ADDR_M      = 4;
   localparam int unsigned ADDR_BTHR   = 5;
   localparam int unsigned ADDR_AMIN   = 6;
   localparam int unsigned ADDR_AMAX   = 7;
   localparam int unsigned ADDR_BMIN   = 8;
   localparam int unsigned ADDR_BMAX   = 9;
   localparam int unsigned IMG_BASE    = 10;
   localparam int unsigned MAX_IMG     = 720;

   localparam int unsigned CTRL_START  = 0;
   localparam int unsigned CTRL_CLRERR = 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic                       is_ctrl;
      logic                       is_param;
      logic                       is_prim;
      logic                       is_wm;
      logic                       is_oob;
      logic [AMBA_ADDR_DEPTH-1:0] bank_addr;
   } dec_t;

endpackage

// File: rtl/wm_addr_decode.sv
// Flat address map decode: CTRL, parameter window, primary bank, watermark bank, out of range.
module wm_addr_decode
   import wm_pkg::*;
(
   input  logic [PADDR_W-1:0] i_paddr,
   input  logic [SQ_W-1:0]    i_np_sq,
   input  logic [SQ_W-1:0]    i_nw_sq,
   output dec_t               o_dec
);

   logic [SPAN_W-1:0] w_off;
   logic [SPAN_W-1:0] w_prim_end;
   logic [SPAN_W-1:0] w_img_end;
   logic              w_is_ctrl;
   logic              w_is_img;
   logic              w_in_prim;
   logic              w_in_wm;

   always_comb begin
      w_off      = SPAN_W'(i_paddr) - SPAN_W'(IMG_BASE);
      w_prim_end = SPAN_W'(i_np_sq);
      w_img_end  = SPAN_W'(i_np_sq) + SPAN_W'(i_nw_sq);
      w_is_ctrl  = (i_paddr == PADDR_W'(ADDR_CTRL));
      w_is_img   = (SPAN_W'(i_paddr) >= SPAN_W'(IMG_BASE));
      w_in_prim  = w_is_img && (w_off < w_prim_end);
      w_in_wm    = w_is_img && !w_in_prim && (w_off < w_img_end);
   end

   always_comb begin
      o_dec           = '0;
      o_dec.is_ctrl   = w_is_ctrl;
      o_dec.is_param  = !w_is_img && !w_is_ctrl;
      o_dec.is_prim   = w_in_prim;
      o_dec.is_wm     = w_in_wm;
      o_dec.is_oob    = w_is_img && !w_in_prim && !w_in_wm;
      o_dec.bank_addr = w_in_wm ? AMBA_ADDR_DEPTH'(w_off - w_prim_end)
                                : AMBA_ADDR_DEPTH'(w_off);
   end

endmodule

// File: rtl/wm_apb_loader.sv
// APB slave loader: parameter registers, image-bank write ports, engine start/busy tracking.
module wm_apb_loader
   import wm_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       PSEL,
   input  logic                       PENABLE,
   input  logic                       PWRITE,
   input  logic [PADDR_W-1:0]         PADDR,
   input  logic [AMBA_WORD-1:0]       PWDATA,
   output logic [AMBA_WORD-1:0]       PRDATA,
   input  logic                       Image_Done,
   output logic [SIDE_W-1:0]          Np,
   output logic [SIDE_W-1:0]          Nw,
   output logic [DATA_DEPTH-1:0]      Iwhite,
   output logic [DATA_DEPTH-1:0]      M,
   output logic [DATA_DEPTH-1:0]      Bthr,
   output logic [DATA_DEPTH-1:0]      Amin,
   output logic [DATA_DEPTH-1:0]      Amax,
   output logic [DATA_DEPTH-1:0]      Bmin,
   output logic [DATA_DEPTH-1:0]      Bmax,
   output logic                       prim_we,
   output logic                       wm_we,
   output logic [AMBA_ADDR_DEPTH-1:0] bank_addr,
   output logic [DATA_DEPTH-1:0]      bank_wdata,
   output logic                       start,
   output logic                       busy
);

   state_t                     r_state, w_next;
   logic [SIDE_W-1:0]          r_np, r_nw;
   logic [SQ_W-1:0]            r_np_sq, r_nw_sq;
   logic [DATA_DEPTH-1:0]      r_iwhite, r_m, r_bthr, r_amin, r_amax, r_bmin, r_bmax;
   logic                       r_prim_we, r_wm_we, r_start, r_busy, r_err;
   logic [AMBA_ADDR_DEPTH-1:0] r_bank_addr;
   logic [DATA_DEPTH-1:0]      r_bank_wdata;

   dec_t w_dec;
   logic w_wr, w_rd, w_busy, w_ld, w_ctrl_wr, w_start_req, w_cfg_ok, w_start;
   logic w_err_set, w_err_clr, w_unused;

   wm_addr_decode u_dec (
      .i_paddr (PADDR),
      .i_np_sq (r_np_sq),
      .i_nw_sq (r_nw_sq),
      .o_dec   (w_dec)
   );

   // Nw*M == Np with M != 0 is the same test as Np%M == 0 && Nw == Np/M.
   always_comb begin
      w_wr        = PSEL && PENABLE && PWRITE;
      w_rd        = PSEL && PENABLE && !PWRITE;
      w_busy      = (r_state == ST_RUN);
      w_ld        = w_wr && !w_busy;
      w_ctrl_wr   = w_wr && w_dec.is_ctrl;
      w_start_req = w_ctrl_wr && PWDATA[CTRL_START] && (r_state == ST_IDLE);
      w_cfg_ok    = (r_m != '0) && ((CFG_W'(r_nw) * CFG_W'(r_m)) == CFG_W'(r_np));
      w_err_set   = (w_start_req && !w_cfg_ok) || (w_ld && w_dec.is_oob);
      w_err_clr   = w_ctrl_wr && PWDATA[CTRL_CLRERR];
      w_unused    = ^PWDATA[AMBA_WORD-1:SIDE_W];
   end

   // Engine FSM; a concurrent Image_Done wins over a start request.
   always_comb begin
      w_next  = r_state;
      w_start = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_start_req && w_cfg_ok && !Image_Done) begin
               w_next  = ST_RUN;
               w_start = 1'b1;
            end
         end
         ST_RUN: begin
            if (Image_Done) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= ST_IDLE;
         r_busy       <= 1'b0;
         r_start      <= 1'b0;
         r_err        <= 1'b0;
         r_np         <= '0;
         r_nw         <= '0;
         r_np_sq      <= '0;
         r_nw_sq      <= '0;
         r_iwhite     <= '0;
         r_m          <= '0;
         r_bthr       <= '0;
         r_amin       <= '0;
         r_amax       <= '0;
         r_bmin       <= '0;
         r_bmax       <= '0;
         r_prim_we    <= 1'b0;
         r_wm_we      <= 1'b0;
         r_bank_addr  <= '0;
         r_bank_wdata <= '0;
      end else begin
         r_state   <= w_next;
         r_busy    <= (w_next == ST_RUN);
         r_start   <= w_start;
         r_err     <= w_err_set ? 1'b1 : (w_err_clr ? 1'b0 : r_err);
         r_prim_we <= w_ld && w_dec.is_prim;
         r_wm_we   <= w_ld && w_dec.is_wm;
         if (w_ld && (w_dec.is_prim || w_dec.is_wm)) begin
            r_bank_addr  <= w_dec.bank_addr;
            r_bank_wdata <= PWDATA[DATA_DEPTH-1:0];
         end
         // Side-length writes preload their squares so the next access decodes against them.
         if (w_ld && w_dec.is_param) begin
            case (PADDR[3:0])
               4'(ADDR_IWHITE): r_iwhite <= PWDATA[DATA_DEPTH-1:0];
               4'(ADDR_NP): begin
                  r_np    <= PWDATA[SIDE_W-1:0];
                  r_np_sq <= SQ_W'(PWDATA[SIDE_W-1:0]) * SQ_W'(PWDATA[SIDE_W-1:0]);
               end
               4'(ADDR_NW): begin
                  r_nw    <= PWDATA[SIDE_W-1:0];
                  r_nw_sq <= SQ_W'(PWDATA[SIDE_W-1:0]) * SQ_W'(PWDATA[SIDE_W-1:0]);
               end
               4'(ADDR_M):    r_m    <= PWDATA[DATA_DEPTH-1:0];
               4'(ADDR_BTHR): r_bthr <= PWDATA[DATA_DEPTH-1:0];
               4'(ADDR_AMIN): r_amin <= PWDATA[DATA_DEPTH-1:0];
               4'(ADDR_AMAX): r_amax <= PWDATA[DATA_DEPTH-1:0];
               4'(ADDR_BMIN): r_bmin <= PWDATA[DATA_DEPTH-1:0];
               4'(ADDR_BMAX): r_bmax <= PWDATA[DATA_DEPTH-1:0];
               default: ;
            endcase
         end
      end
   end

   // Read data is combinational within the access cycle.
   always_comb begin
      PRDATA = '0;
      if (w_rd && w_dec.is_ctrl) begin
         PRDATA = AMBA_WORD'({r_err, Image_Done, r_busy});
      end else if (w_rd && w_dec.is_param) begin
         case (PADDR[3:0])
            4'(ADDR_IWHITE): PRDATA = AMBA_WORD'(r_iwhite);
            4'(ADDR_NP):     PRDATA = AMBA_WORD'(r_np);
            4'(ADDR_NW):     PRDATA = AMBA_WORD'(r_nw);
            4'(ADDR_M):      PRDATA = AMBA_WORD'(r_m);
            4'(ADDR_BTHR):   PRDATA = AMBA_WORD'(r_bthr);
            4'(ADDR_AMIN):   PRDATA = AMBA_WORD'(r_amin);
            4'(ADDR_AMAX):   PRDATA = AMBA_WORD'(r_amax);
            4'(ADDR_BMIN):   PRDATA = AMBA_WORD'(r_bmin);
            4'(ADDR_BMAX):   PRDATA = AMBA_WORD'(r_bmax);
            default:         PRDATA = '0;
         endcase
      end
   end

   assign Np         = r_np;
   assign Nw         = r_nw;
   assign Iwhite     = r_iwhite;
   assign M          = r_m;
   assign Bthr       = r_bthr;
   assign Amin       = r_amin;
   assign Amax       = r_amax;
   assign Bmin       = r_bmin;
   assign Bmax       = r_bmax;
   assign prim_we    = r_prim_we;
   assign wm_we      = r_wm_we;
   assign bank_addr  = r_bank_addr;
   assign bank_wdata = r_bank_wdata;
   assign start      = r_start;
   assign busy       = r_busy;

endmodule
